// File: rtl/hilo_mdu_if.sv
// rtl/hilo_mdu_if.sv - request/result bundle between control unit and the HI/LO multiply/divide unit
interface hilo_mdu_if;
    logic        req;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (output req, op, a, b, input hi, lo, busy, done);
    modport slave  (input req, op, a, b, output hi, lo, busy, done);
endinterface

// File: rtl/hilo_mdu.sv
// rtl/hilo_mdu.sv - iterative MULT/MULTU/DIV/DIVU + MTHI/MTLO unit owning HI/LO (option: HILO_MDU_FAST_MUL_EN)
module hilo_mdu (
    input  logic       clk,
    input  logic       rst_n,
    hilo_mdu_if.slave  bus
);
    typedef enum logic {IDLE, CALC} state_t;

    state_t      state, state_nx;
    logic [5:0]  cnt;
    logic [63:0] p;          // mul: {acc, multiplier}; div: {remainder, quotient}
    logic [31:0] dvsr;       // multiplicand or divisor magnitude
    logic        is_div;
    logic        neg_q;      // negate product / quotient at the end
    logic        neg_r;      // negate remainder at the end
    logic [31:0] hi_r, lo_r;
    logic        done_r, done_nx;

    logic        sgn, dbz, last;
    logic [31:0] a_mag, b_mag;
    logic [63:0] p_next;
    logic [32:0] rem_sh, trial;
    logic [63:0] div_next, prod;
    logic [31:0] res_hi, res_lo;

    // operand preparation for an incoming request
    always_comb begin
        sgn   = ~bus.op[0];
        a_mag = (sgn && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
        b_mag = (sgn && bus.b[31]) ? (32'd0 - bus.b) : bus.b;
        dbz   = bus.op[1] && (bus.b == 32'd0);
    end

    // one iteration step and final sign correction
    always_comb begin
        rem_sh   = p[63:31];
        trial    = rem_sh - {1'b0, dvsr};
        div_next = trial[32] ? {rem_sh[31:0], p[30:0], 1'b0}
                             : {trial[31:0],  p[30:0], 1'b1};
        p_next   = div_next;
        last     = (cnt == 6'd31);
`ifdef HILO_MDU_FAST_MUL_EN
        if (!is_div) begin
            p_next = {32'd0, p[31:0]} * {32'd0, dvsr};
            last   = 1'b1;
        end
`else
        if (!is_div) begin
            p_next = {({1'b0, p[63:32]} + (p[0] ? {1'b0, dvsr} : 33'd0)), p[31:1]};
        end
`endif
        prod   = neg_q ? (64'd0 - p_next) : p_next;
        res_lo = neg_q ? (32'd0 - p_next[31:0])  : p_next[31:0];
        res_hi = neg_r ? (32'd0 - p_next[63:32]) : p_next[63:32];
        if (!is_div) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

    // next state and completion pulse
    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        case (state)
            IDLE: if (bus.req && !bus.op[2]) state_nx = CALC;
            CALC: if (last) begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // datapath: accept, iterate, commit HI/LO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= 6'd0;
            p      <= 64'd0;
            dvsr   <= 32'd0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
            done_r <= 1'b0;
        end else begin
            done_r <= done_nx;
            if (state == IDLE) begin
                cnt <= 6'd0;
                if (bus.req) begin
                    case (bus.op)
                        3'b100: hi_r <= bus.a;
                        3'b101: lo_r <= bus.a;
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            is_div <= bus.op[1];
                            if (dbz) begin
                                // divide by a zero divisor on the raw dividend yields
                                // quotient all-ones and remainder = a, with no sign fix-up
                                p     <= {32'd0, bus.a};
                                dvsr  <= 32'd0;
                                neg_q <= 1'b0;
                                neg_r <= 1'b0;
                            end else begin
                                p     <= {32'd0, a_mag};
                                dvsr  <= b_mag;
                                neg_q <= sgn & (bus.a[31] ^ bus.b[31]);
                                neg_r <= sgn & bus.a[31] & bus.op[1];
                            end
                        end
                        default: ;
                    endcase
                end
            end else begin
                cnt <= cnt + 6'd1;
                p   <= p_next;
                if (last) begin
                    hi_r <= res_hi;
                    lo_r <= res_lo;
                end
            end
        end
    end

    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.busy = (state == CALC);
    assign bus.done = done_r;
endmodule

// File: tb/tb_hilo_mdu.sv
// tb/tb_hilo_mdu.sv - scoreboard bench for hilo_mdu (honours HILO_MDU_FAST_MUL_EN)
module tb_hilo_mdu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hilo_mdu_if bus();
    hilo_mdu dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

`ifdef HILO_MDU_FAST_MUL_EN
    localparam int MUL_BUSY = 1;
`else
    localparam int MUL_BUSY = 32;
`endif
    localparam int DIV_BUSY = 32;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest expected result
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no done", bus.hi, bus.lo);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_hi", bus.hi, e[63:32]);
                    chk("result_lo", bus.lo, e[31:0]);
                end
            end
        end
    end

    task automatic wait_done(input string name, output int bc);
        bit got;
        bc  = 0;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done === 1'b1) begin
                got = 1;
                break;
            end
            if (bus.busy === 1'b1) bc++;
            @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 100 cycles", name);
        end
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input int exp_busy);
        int bc;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.req = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.req = 1'b0;
        wait_done(name, bc);
        chk({name, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
        @(negedge clk);
        chk({name, "_done_width"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int bc;
        bus.req = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_hi",   bus.hi, 32'd0);
        chk("reset_lo",   bus.lo, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        rst_n = 1'b1;

        run("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, MUL_BUSY);
        run("mult_neg3x5", 3'b000, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, MUL_BUSY);
        run("mult_7xneg6", 3'b000, 32'd7, 32'hFFFFFFFA, 64'hFFFFFFFF_FFFFFFD6, MUL_BUSY);
        run("div_neg7d2", 3'b010, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, DIV_BUSY);
        run("divu_by0", 3'b011, 32'd100, 32'd0, 64'h00000064_FFFFFFFF, DIV_BUSY);
        run("div_neg5_by0", 3'b010, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF, DIV_BUSY);
        run("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, DIV_BUSY);
        run("divu_12d4", 3'b011, 32'd12, 32'd4, 64'h00000000_00000003, DIV_BUSY);

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        bus.req = 1'b1; bus.op = 3'b100; bus.a = 32'h12345678;
        @(negedge clk);
        bus.op = 3'b101; bus.a = 32'h9ABCDEF0;
        chk("mthi_hi",   bus.hi, 32'h12345678);
        chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        bus.req = 1'b0;
        chk("mtlo_lo", bus.lo, 32'h9ABCDEF0);
        chk("mtlo_hi", bus.hi, 32'h12345678);

        // reserved op codes do nothing
        @(negedge clk);
        bus.req = 1'b1; bus.op = 3'b110; bus.a = 32'h55555555; bus.b = 32'd3;
        @(negedge clk);
        bus.op = 3'b111;
        @(negedge clk);
        bus.req = 1'b0;
        chk("rsvd_hi",   bus.hi, 32'h12345678);
        chk("rsvd_lo",   bus.lo, 32'h9ABCDEF0);
        chk("rsvd_busy", {31'd0, bus.busy}, 32'd0);

        // requests during CALC are ignored
        exp_q.push_back(64'h00000000_00000006);
        @(negedge clk);
`ifdef HILO_MDU_FAST_MUL_EN
        bus.req = 1'b1; bus.op = 3'b011; bus.a = 32'd6; bus.b = 32'd1;
`else
        bus.req = 1'b1; bus.op = 3'b001; bus.a = 32'd2; bus.b = 32'd3;
`endif
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        bus.req = 1'b1; bus.op = 3'b100; bus.a = 32'h0000DEAD;
        @(negedge clk);
        bus.op = 3'b011; bus.a = 32'd50; bus.b = 32'd5;
        @(negedge clk);
        bus.req = 1'b0;
        chk("calc_hi_held",  bus.hi, 32'h12345678);
        chk("calc_busy",     {31'd0, bus.busy}, 32'd1);
        wait_done("ignore", bc);
        repeat (40) @(negedge clk);
        chk("ignore_busy", {31'd0, bus.busy}, 32'd0);
        chk("ignore_lo",   bus.lo, 32'd6);
        chk("ignore_hi",   bus.hi, 32'd0);

        // reset aborts an operation in flight
        @(negedge clk);
        bus.req = 1'b1; bus.op = 3'b011; bus.a = 32'd1000; bus.b = 32'd7;
        @(negedge clk);
        bus.req = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_hi",   bus.hi, 32'd0);
        chk("abort_lo",   bus.lo, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_lo_after", bus.lo, 32'd0);
        run("multu_7x6", 3'b001, 32'd7, 32'd6, 64'h00000000_0000002A, MUL_BUSY);

        repeat (2) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
